// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB requester arbiter.
//   ArbState   - FSM encoding (IDLE, SETUP, ACCESS)
//   PROT_WIDTH - width of the APB PPROT field
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } ArbState;

  localparam int unsigned PROT_WIDTH = 3;

endpackage

// File: rtl/apb_requester_arbiter_if.sv
// APB bus bundle between the arbiter and a single completer.
//   master modport: drives PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT,
//                   receives PRDATA/PREADY/PSLVERR
//   slave modport : the mirror image, for the completer side
interface apb_requester_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  import apb_arb_pkg::*;

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [PROT_WIDTH-1:0]   PPROT;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req        - request vector, one bit per requester
//   last       - index of the most recently served requester
//   gnt_onehot - one-hot grant (all zero when nothing requests)
//   gnt_idx    - binary index of the grant
//   any        - at least one request is pending
// Search starts at last+1 and wraps modulo N, so the previous winner has lowest priority.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int unsigned IdxW = $clog2(N);

  always_comb begin
    logic        found;
    int unsigned idx;
    found   = 1'b0;
    idx     = 0;
    gnt_idx = '0;
    any     = |req;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      if (!found && req[idx[IdxW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[IdxW-1:0];
      end
    end
    gnt_onehot = any ? (N'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/apb_requester_arbiter.sv
// Shares one APB requester port between NREQ on-chip requesters.
//   PCLK, PRESET       - clock and synchronous active-high reset
//   req_valid/write    - per-requester request and direction (held until req_done)
//   req_addr/wdata/strb/prot - packed per-requester transfer fields, slice i = requester i
//   req_done           - one-cycle one-hot completion pulse
//   rsp_rdata/rsp_error - completion data/status, zero outside the completion cycle
//   busy, grant_id     - transfer in flight, and index of the bus owner
//   apb                - APB master port towards the completer
// A transfer takes IDLE -> SETUP -> ACCESS; the access phase ends on PREADY or after
// TIMEOUT wait cycles (TIMEOUT = 0 disables the timeout).
module apb_requester_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0]              req_write,
  input  logic [NREQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NREQ*DATA_WIDTH/8-1:0] req_strb,
  input  logic [NREQ*PROT_WIDTH-1:0]   req_prot,
  output logic [NREQ-1:0]              req_done,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_error,
  output logic                         busy,
  output logic [$clog2(NREQ)-1:0]      grant_id,
  apb_requester_arbiter_if.master      apb
);

  localparam int unsigned IdxW  = $clog2(NREQ);
  localparam int unsigned StrbW = DATA_WIDTH / 8;
  // Keep at least one bit so TIMEOUT = 0 still elaborates.
  localparam int unsigned CntW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  ArbState               state_q;
  logic [CntW-1:0]       wait_cnt_q;
  logic [IdxW-1:0]       last_grant_q;
  logic [IdxW-1:0]       grant_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [StrbW-1:0]      pstrb_q;
  logic [PROT_WIDTH-1:0] pprot_q;

  logic [NREQ-1:0]       gnt_onehot;
  logic [IdxW-1:0]       gnt_idx;
  logic                  gnt_any;

  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [StrbW-1:0]      sel_strb;
  logic [PROT_WIDTH-1:0] sel_prot;

  logic                  timeout_hit;
  logic                  complete;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last       (last_grant_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // AND-OR mux of the winning requester's fields.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    sel_prot  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_onehot[i]) begin
        sel_write |= req_write[i];
        sel_addr  |= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata |= req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  |= req_strb[i*StrbW +: StrbW];
        sel_prot  |= req_prot[i*PROT_WIDTH +: PROT_WIDTH];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CntW'(TIMEOUT - 1));
  assign complete    = (state_q == ACCESS) && (apb.PREADY || timeout_hit);

  // Completion response is combinational so it lines up with the PREADY cycle.
  always_comb begin
    req_done  = complete ? (NREQ'(1) << grant_q) : '0;
    rsp_rdata = (complete && apb.PREADY) ? apb.PRDATA : '0;
    rsp_error = complete && (apb.PREADY ? apb.PSLVERR : 1'b1);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      last_grant_q <= IdxW'(NREQ - 1);
      grant_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pprot_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            grant_q    <= gnt_idx;
            pwrite_q   <= sel_write;
            paddr_q    <= sel_addr;
            pwdata_q   <= sel_wdata;
            pstrb_q    <= sel_write ? sel_strb : '0;
            pprot_q    <= sel_prot;
            psel_q     <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (complete) begin
            last_grant_q <= grant_q;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            state_q      <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_q;
  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;
  assign apb.PSTRB   = pstrb_q;
  assign apb.PPROT   = pprot_q;

endmodule
